leds7_scan_ctrl: RTL and testbench

LEDS7_SCAN_CTRL -- requirements
Module: leds7_scan_ctrl

---
 rtl/leds7_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_leds7_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/leds7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// leds7_scan_ctrl: two-requester round-robin writer into four 7-segment digits
// with per-digit blinking and a sticky invalid-value error.  Rev 1.0
// ============================================================================
module leds7_scan_ctrl #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [1:0] a_digit,
  input  logic [3:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [1:0] b_digit,
  input  logic [3:0] b_data,
  input  logic [3:0] blink_en,
  input  logic       clr_err,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       err
);

  localparam int              CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [0:0]      GRANT_A = 1'b0;
  localparam logic [0:0]      GRANT_B = 1'b1;
  localparam logic [3:0]      BLANK   = 4'hF;
  localparam logic [6:0]      SEG_OFF = 7'h7F;

  logic [0:0]       last_grant_q, last_grant_d;
  logic [3:0]       digit_q [4];
  logic [3:0]       digit_d [4];
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [6:0]       hex_q [4];
  logic [6:0]       hex_d [4];

  logic             a_gnt, b_gnt, xfer;
  logic [1:0]       sel_digit;
  logic [3:0]       sel_data;
  logic             bad_value;

  // Active-low segment pattern, bit6 = a ... bit0 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] abcdefg;
    case (v)
      4'd0:    abcdefg = 7'b1111110;
      4'd1:    abcdefg = 7'b0110000;
      4'd2:    abcdefg = 7'b1101101;
      4'd3:    abcdefg = 7'b1111001;
      4'd4:    abcdefg = 7'b0110011;
      4'd5:    abcdefg = 7'b1011011;
      4'd6:    abcdefg = 7'b0011111;
      4'd7:    abcdefg = 7'b1110000;
      4'd8:    abcdefg = 7'b1111111;
      4'd9:    abcdefg = 7'b1110011;
      default: abcdefg = 7'b0000000;
    endcase
    return ~abcdefg;
  endfunction

  // Contention goes to whoever did not win last time.
  always_comb begin
    a_gnt = reset_n & a_valid & (~b_valid | (last_grant_q == GRANT_B));
    b_gnt = reset_n & b_valid & (~a_valid | (last_grant_q == GRANT_A));
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  always_comb begin
    xfer         = a_gnt | b_gnt;
    sel_digit    = a_gnt ? a_digit : b_digit;
    sel_data     = a_gnt ? a_data  : b_data;
    bad_value    = xfer && (sel_data > 4'd9);
    last_grant_d = last_grant_q;
    if (a_gnt) begin
      last_grant_d = GRANT_A;
    end else if (b_gnt) begin
      last_grant_d = GRANT_B;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (xfer) begin
      digit_d[sel_digit] = bad_value ? BLANK : sel_data;
    end
  end

  // Set has priority over a coincident clear.
  always_comb begin
    err_d = (err_q & ~clr_err) | bad_value;
  end

  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
    end
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_hex
      always_comb begin
        if ((digit_q[n] == BLANK) || (blink_en[n] && phase_q)) begin
          hex_d[n] = SEG_OFF;
        end else begin
          hex_d[n] = seg_decode(digit_q[n]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_B;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= BLANK;
        hex_q[i]   <= SEG_OFF;
      end
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= digit_d[i];
        hex_q[i]   <= hex_d[i];
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_leds7_scan_ctrl.sv
`default_nettype none
// Testbench for leds7_scan_ctrl: directed scenarios plus constrained-random
// traffic, checked by a scoreboard against a cycle-count reference model.
module tb_leds7_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [1:0] a_digit = '0, b_digit = '0;
  logic [3:0] a_data = '0, b_data = '0;
  logic [3:0] blink_en = '0;
  logic       clr_err = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       err;

  leds7_scan_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_digit(a_digit), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_digit(b_digit), .b_data(b_data),
    .blink_en(blink_en), .clr_err(clr_err),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           ar;
    logic           br;
    logic [3:0][6:0] hex;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: displayed values, sticky error, who won last, and the
  // number of clock edges since reset (blink phase derives from that count).
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
                               7'b1111111, 7'b1110011};
  int   m_val [4];
  logic m_err;
  logic m_last_b;
  int   m_edges;
  logic g_a, g_b;

  task automatic drive(input logic rn, input logic av, input logic [1:0] ad,
                       input logic [3:0] adat, input logic bv,
                       input logic [1:0] bd, input logic [3:0] bdat,
                       input logic [3:0] ben, input logic clr);
    exp_t e;
    int   phase;
    int   d, v;
    reset_n = rn; a_valid = av; a_digit = ad; a_data = adat;
    b_valid = bv; b_digit = bd; b_data = bdat; blink_en = ben; clr_err = clr;
    if (!rn) begin
      g_a = 1'b0; g_b = 1'b0;
    end else if (av && bv) begin
      g_a = m_last_b; g_b = !m_last_b;
    end else begin
      g_a = av; g_b = bv;
    end
    phase = (m_edges / DIV) % 2;
    e.ar = g_a;
    e.br = g_b;
    for (int i = 0; i < 4; i++) begin
      if (!rn || m_val[i] > 9 || (ben[i] && phase == 1)) e.hex[i] = 7'h7F;
      else e.hex[i] = ~seg_tab[m_val[i]];
    end
    if (!rn) begin
      for (int i = 0; i < 4; i++) m_val[i] = 15;
      m_err = 1'b0; m_last_b = 1'b1; m_edges = 0;
    end else begin
      m_edges++;
      m_err = m_err & ~clr;
      if (g_a || g_b) begin
        d = g_a ? int'(ad) : int'(bd);
        v = g_a ? int'(adat) : int'(bdat);
        m_last_b = g_b;
        m_val[d] = (v > 9) ? 15 : v;
        if (v > 9) m_err = 1'b1;
      end
    end
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic av, input logic [1:0] ad,
                      input logic [3:0] adat, input logic bv,
                      input logic [1:0] bd, input logic [3:0] bdat,
                      input logic [3:0] ben, input logic clr);
    @(negedge clk);
    drive(rn, av, ad, adat, bv, bd, bdat, ben, clr);
  endtask

  task automatic idle(input int n, input logic [3:0] ben);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, ben, 0);
  endtask

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // Monitor: readies sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic ar_s, br_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      ar_s = a_ready;
      br_s = b_ready;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("a_ready", {6'b0, ar_s}, {6'b0, e.ar});
        cmp("b_ready", {6'b0, br_s}, {6'b0, e.br});
        cmp("hex0", hex0, e.hex[0]);
        cmp("hex1", hex1, e.hex[1]);
        cmp("hex2", hex2, e.hex[2]);
        cmp("hex3", hex3, e.hex[3]);
        cmp("err", {6'b0, err}, {6'b0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pa, pb, av, bv, rn, clr;
    logic [1:0] ad, bd;
    logic [3:0] adat, bdat, ben;
    for (int i = 0; i < 4; i++) m_val[i] = 15;
    m_err = 1'b0; m_last_b = 1'b1; m_edges = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single writer, then contention, then continuous contention on digit 3.
    step(1, 1, 2, 7, 0, 0, 0, 0, 0);
    idle(2, 0);
    step(1, 1, 0, 3, 1, 1, 5, 0, 0);
    step(1, 1, 0, 3, 1, 1, 5, 0, 0);
    idle(2, 0);
    for (int k = 0; k < 8; k++) step(1, 1, 3, 1, 1, 3, 8, 0, 0);
    idle(2, 0);

    // Invalid value, clear, clear coincident with another invalid write.
    step(1, 1, 0, 12, 0, 0, 0, 0, 0);
    idle(2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    step(1, 0, 0, 0, 1, 2, 15, 0, 1);
    idle(2, 0);

    // Blink on digit 1 only.
    step(1, 1, 1, 0, 0, 0, 0, 4'b0010, 0);
    idle(20, 4'b0010);
    idle(3, 4'b0000);

    // Reset while B is requesting.
    step(0, 0, 0, 0, 1, 0, 4, 0, 0);
    idle(3, 0);

    // Random traffic; an ungranted request is held unchanged until granted.
    pa = 0; pb = 0; av = 0; bv = 0; ad = 0; bd = 0; adat = 0; bdat = 0; ben = 0;
    for (int k = 0; k < 3000; k++) begin
      rn = ($urandom_range(0, 60) != 0);
      if (!pa) begin
        av = ($urandom_range(0, 9) < 6);
        ad = 2'($urandom_range(0, 3));
        adat = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if (!pb) begin
        bv = ($urandom_range(0, 9) < 6);
        bd = 2'($urandom_range(0, 3));
        bdat = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) ben = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 9) == 0);
      step(rn, av, ad, adat, bv, bd, bdat, ben, clr);
      pa = rn && av && !g_a;
      pb = rn && bv && !g_b;
    end
    idle(3, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
